// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, 2-entry {addr, instr} FIFO
// feeding ID, and branch redirect with an in-flight response discard.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] instruction,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic        req_reg;
  logic [31:0] req_addr_reg;
  logic [1:0]  count_reg;
  logic        rd_ptr_reg;
  logic        wr_ptr_reg;

  logic        enq;
  logic        deq;
  logic [31:0] head_addr;
  logic [31:0] head_instr;

  // A branch in the same cycle cancels both queue operations.
  assign enq = (state_reg == S_WAIT) && imem_ack && !branch_taken;
  assign deq = (count_reg != 2'd0) && !freeze && !branch_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fetch_pc_reg <= RESET_PC;
      req_reg      <= 1'b0;
      req_addr_reg <= RESET_PC;
      count_reg    <= 2'd0;
      rd_ptr_reg   <= 1'b0;
      wr_ptr_reg   <= 1'b0;
    end else begin
      if (branch_taken) begin
        count_reg  <= 2'd0;
        rd_ptr_reg <= 1'b0;
        wr_ptr_reg <= 1'b0;
      end else begin
        if (enq) wr_ptr_reg <= ~wr_ptr_reg;
        if (deq) rd_ptr_reg <= ~rd_ptr_reg;
        unique case ({enq, deq})
          2'b10:   count_reg <= count_reg + 2'd1;
          2'b01:   count_reg <= count_reg - 2'd1;
          default: count_reg <= count_reg;
        endcase
      end

      unique case (state_reg)
        S_IDLE: begin
          if (branch_taken) begin
            fetch_pc_reg <= branch_addr;
          end else if (count_reg != 2'd2) begin
            // Only our own response can enqueue, so count<2 here guarantees a free slot.
            state_reg    <= S_WAIT;
            req_reg      <= 1'b1;
            req_addr_reg <= fetch_pc_reg;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            state_reg    <= S_IDLE;
            req_reg      <= 1'b0;
            fetch_pc_reg <= branch_taken ? branch_addr : fetch_pc_reg + 32'd4;
          end else if (branch_taken) begin
            state_reg    <= S_DISCARD;
            fetch_pc_reg <= branch_addr;
          end
        end
        S_DISCARD: begin
          if (branch_taken) fetch_pc_reg <= branch_addr;
          if (imem_ack) begin
            state_reg <= S_IDLE;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO payload storage; no reset needed since count gates visibility.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [31:0] addr_reg;
      logic [31:0] instr_reg;
      always_ff @(posedge clk) begin
        if (enq && (wr_ptr_reg == 1'(gi))) begin
          addr_reg  <= fetch_pc_reg;
          instr_reg <= imem_rdata;
        end
      end
    end
  endgenerate

  assign head_addr  = rd_ptr_reg ? g_entry[1].addr_reg  : g_entry[0].addr_reg;
  assign head_instr = rd_ptr_reg ? g_entry[1].instr_reg : g_entry[0].instr_reg;

  assign imem_req    = req_reg;
  assign imem_addr   = req_addr_reg;
  assign valid       = (count_reg != 2'd0);
  assign instruction = valid ? head_instr : 32'h0;
  assign PC          = valid ? head_addr + 32'd4 : 32'h0;

  enq_into_full_fifo: assert property (@(posedge clk) disable iff (rst)
    !(enq && count_reg == 2'd2));

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, freeze backpressure, branch
// redirects, reset during an outstanding request and PC wrap.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] PC;

  int n_vec = 0;
  int n_bad = 0;
  bit auto_ack = 1'b0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .valid        (valid),
    .instruction  (instruction),
    .PC           (PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one clock, settle, then let the memory model (0-wait) answer any request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      imem_ack   = imem_req;
      imem_rdata = imem_req ? (imem_addr ^ 32'hE000_0000) : 32'h0;
    end
  endtask

  task automatic do_reset(input string tag);
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    tick();
    tick();
    check({tag, " rst valid"}, 32'(valid), 32'h0);
    check({tag, " rst instr"}, instruction, 32'h0);
    check({tag, " rst PC"}, PC, 32'h0);
    check({tag, " rst req"}, 32'(imem_req), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    // Streaming, 0-wait memory
    auto_ack = 1'b1;
    do_reset("stream");
    tick();
    check("stream req0", 32'(imem_req), 32'h1);
    check("stream addr0", imem_addr, 32'h0);
    check("stream valid before ack", 32'(valid), 32'h0);
    tick();
    check("stream valid0", 32'(valid), 32'h1);
    check("stream PC0", PC, 32'h4);
    check("stream instr0", instruction, 32'hE000_0000);
    check("stream req idle", 32'(imem_req), 32'h0);
    tick();
    check("stream valid gap", 32'(valid), 32'h0);
    check("stream addr1", imem_addr, 32'h4);
    tick();
    check("stream PC1", PC, 32'h8);
    check("stream instr1", instruction, 32'hE000_0004);
    tick();
    check("stream addr2", imem_addr, 32'h8);
    tick();
    check("stream PC2", PC, 32'hC);
    check("stream instr2", instruction, 32'hE000_0008);

    // Freeze fills the FIFO and stalls requests
    do_reset("freeze");
    freeze = 1'b1;
    tick();
    tick();
    check("freeze PC first", PC, 32'h4);
    tick();
    check("freeze req second", 32'(imem_req), 32'h1);
    check("freeze addr second", imem_addr, 32'h4);
    tick();
    check("freeze full req", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze hold req", 32'(imem_req), 32'h0);
      check("freeze hold PC", PC, 32'h4);
      check("freeze hold instr", instruction, 32'hE000_0000);
    end
    freeze = 1'b0;
    tick();
    check("unfreeze PC", PC, 32'h8);
    check("unfreeze instr", instruction, 32'hE000_0004);
    check("unfreeze req", 32'(imem_req), 32'h0);
    tick();
    check("unfreeze empty", 32'(valid), 32'h0);
    check("unfreeze addr", imem_addr, 32'h8);
    check("unfreeze req2", 32'(imem_req), 32'h1);
    tick();
    check("unfreeze PC next", PC, 32'hC);

    // Branch while waiting on addr 0x8; late response must be dropped
    do_reset("discard");
    for (int i = 0; i < 4; i++) tick();
    auto_ack = 1'b0;
    imem_ack = 1'b0;
    tick();
    check("discard addr8", imem_addr, 32'h8);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();
    branch_taken = 1'b0;
    check("discard req held", 32'(imem_req), 32'h1);
    check("discard addr held", imem_addr, 32'h8);
    check("discard valid", 32'(valid), 32'h0);
    tick();
    check("discard still req", 32'(imem_req), 32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("discard drop valid", 32'(valid), 32'h0);
    check("discard drop req", 32'(imem_req), 32'h0);
    tick();
    check("discard new req", 32'(imem_req), 32'h1);
    check("discard new addr", imem_addr, 32'h100);
    imem_ack   = 1'b1;
    imem_rdata = 32'hE000_0100;
    tick();
    imem_ack = 1'b0;
    check("discard new valid", 32'(valid), 32'h1);
    check("discard new PC", PC, 32'h104);
    check("discard new instr", instruction, 32'hE000_0100);

    // Branch coincident with ack and dequeue
    auto_ack = 1'b1;
    do_reset("bracksame");
    freeze = 1'b1;
    tick();
    tick();
    tick();
    check("bracksame pre valid", 32'(valid), 32'h1);
    check("bracksame pre ack", 32'(imem_ack), 32'h1);
    freeze       = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();
    branch_taken = 1'b0;
    check("bracksame valid", 32'(valid), 32'h0);
    check("bracksame instr", instruction, 32'h0);
    check("bracksame PC", PC, 32'h0);
    tick();
    check("bracksame addr", imem_addr, 32'h200);
    tick();
    check("bracksame new PC", PC, 32'h204);
    check("bracksame new instr", instruction, 32'hE000_0200);

    // Reset while a request is outstanding
    auto_ack = 1'b0;
    do_reset("rstwait");
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    tick();
    branch_taken = 1'b0;
    tick();
    check("rstwait addr", imem_addr, 32'h300);
    rst = 1'b1;
    tick();
    check("rstwait req", 32'(imem_req), 32'h0);
    rst        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    check("rstwait valid", 32'(valid), 32'h0);
    check("rstwait new req", 32'(imem_req), 32'h1);
    check("rstwait new addr", imem_addr, 32'h0);
    tick();
    check("rstwait no stale", 32'(valid), 32'h0);

    // PC wrap at the top of the address space
    auto_ack = 1'b1;
    do_reset("wrap");
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    check("wrap addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap PC", PC, 32'h0);
    check("wrap instr", instruction, 32'h1FFF_FFFC);
    tick();
    check("wrap next req", 32'(imem_req), 32'h1);
    check("wrap next addr", imem_addr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: freeze  in  1  ID hazard stall; head entry is not consumed.
REQ-005 SHALL have port: branch_taken  in  1  redirect from EXE.
REQ-006 SHALL have port: branch_addr  in  32  redirect target.
REQ-007 SHALL have port: imem_req  out  1  instruction memory request.
REQ-008 SHALL have port: imem_addr  out  32  request address.
REQ-009 SHALL have port: imem_ack  in  1  response valid and request accepted.
REQ-010 SHALL have port: imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-011 SHALL have port: valid  out  1  instruction/PC to ID are meaningful.
REQ-012 SHALL have port: instruction  out  32  head instruction; 32'h0 when valid=0.
REQ-013 SHALL have port: PC  out  32  head fetch address + 4; 32'h0 when valid=0.

Function
REQ-014 SHALL hold fetch_pc (32b), a 2-entry FIFO of {addr, instr}, count (0..2) and a FSM with states IDLE, WAIT, DISCARD.
REQ-015 SHALL allow at most one outstanding memory request.
REQ-016 IDLE: when count<2 and branch_taken=0, SHALL assert imem_req with imem_addr=fetch_pc and go to WAIT next cycle.
REQ-017 WAIT/DISCARD: SHALL keep imem_req=1 and imem_addr stable until the imem_ack cycle; imem_req SHALL be 0 in IDLE.
REQ-018 WAIT with imem_ack=1 and branch_taken=0: SHALL enqueue {fetch_pc, imem_rdata}, set fetch_pc+=4 (mod 2^32 wrap), go to IDLE.
REQ-019 branch_taken=1 in any state: SHALL flush the FIFO (count=0), set fetch_pc=branch_addr, and discard any dequeue or enqueue in that cycle.
REQ-020 branch_taken=1 in WAIT without imem_ack: SHALL go to DISCARD; with imem_ack in the same cycle SHALL drop the data and go to IDLE.
REQ-021 DISCARD: SHALL drop the response on imem_ack and go to IDLE without changing fetch_pc; a further branch in DISCARD SHALL only update fetch_pc.
REQ-022 valid SHALL equal (count!=0); instruction and PC SHALL come from the head entry registers with no combinational path from imem_rdata.
REQ-023 Dequeue SHALL occur when valid=1, freeze=0 and branch_taken=0.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged and preserve order.
REQ-025 Enqueue at count=2 SHALL be impossible by construction (REQ-016); an assertion SHALL flag it.
REQ-026 Minimum latency: issue to valid SHALL be 1 cycle after the ack edge; with 0-wait ack, sustained throughput SHALL be one instruction per 2 cycles.

Reset
REQ-027 On rst=1 at a clock edge: fetch_pc=RESET_PC, count=0, FSM=IDLE, and valid=0, instruction=0, PC=0, imem_req=0 from the next cycle.
REQ-028 Reset SHALL override branch_taken and imem_ack in the same cycle; a response to a request outstanding at reset SHALL be ignored.
REQ-029 First request after reset release SHALL be at RESET_PC in the first cycle with rst=0.

Verification
REQ-030 Reset then ack every request after 1 cycle with rdata=addr^32'hE000_0000 -> valid stream at addrs 0,4,8; PC outputs 4,8,12 with matching instruction.
REQ-031 freeze held 6 cycles from the first valid -> FIFO fills to 2, imem_req stays 0 while count=2, and the head stays instr@0/PC=4 until freeze drops.
REQ-032 branch_taken with branch_addr=0x100 during WAIT for addr 0x8, ack 2 cycles later -> the 0x8 data is dropped and the next request/valid is addr 0x100, PC=0x104.
REQ-033 branch_taken in the same cycle as imem_ack and dequeue -> FIFO empty next cycle, no stale instruction, next imem_addr=branch_addr.
REQ-034 rst asserted while in WAIT, ack arriving the next cycle -> ack ignored, valid=0, next imem_addr=RESET_PC.
REQ-035 fetch_pc=0xFFFF_FFFC fetched -> PC output 0x0000_0000 and the next request at 0x0000_0000.
